// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: three RW control registers and one RO status word.
//
// Register map (addr[3:2]; any address with addr[ADDR_WIDTH-1:4] != 0 is undecoded):
//   0x0 ctrl0 RW | 0x4 ctrl1 RW | 0x8 ctrl2 RW | 0xC status_in RO
//
// Ports:
//   m_axi_aclk, m_axi_aresetn   clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*              write address, data and response channels
//   S_AXI_AR*/R*                 read address and data channels
//   ctrl0_out..ctrl2_out         current RW register contents
//   status_in                    value returned when 0xC is read
//   ctrl_wr_pulse                one-cycle pulse per RW register after each write to it
//
// AW and W are accepted independently and held in latches until both are present.
// Every ready/valid output is a flop, so no output depends combinationally on an input.
module axi4_lite_slave_regfile #(
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            m_axi_aclk,
  input  logic                            m_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [31:0]                     ctrl0_out,
  output logic [31:0]                     ctrl1_out,
  output logic [31:0]                     ctrl2_out,
  input  logic [31:0]                     status_in,
  output logic [2:0]                      ctrl_wr_pulse
);

  localparam int AW = C_S_AXI_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Byte-lane bits of the address are not decoded.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  logic [31:0]   ctrl0_q, ctrl1_q, ctrl2_q;
  logic          aw_lat_q, w_lat_q;
  logic [AW-1:2] aw_addr_q;
  logic [31:0]   w_data_q;
  logic [3:0]    w_strb_q;
  logic          awready_q, wready_q, bvalid_q;
  logic [1:0]    bresp_q;
  logic          arready_q, rvalid_q;
  logic [31:0]   rdata_q;
  logic [1:0]    rresp_q;
  logic [2:0]    pulse_q;

  // Write path
  logic          aw_hs, w_hs, do_write, wr_oor, wr_en, bvalid_n, aw_lat_n, w_lat_n;
  logic [AW-1:2] wr_addr;
  logic [1:0]    wr_idx, wr_resp;
  logic [31:0]   wr_data, wr_cur, wr_merged;
  logic [3:0]    wr_strb;

  always_comb begin
    aw_hs    = S_AXI_AWVALID & awready_q;
    w_hs     = S_AXI_WVALID & wready_q;
    // A channel handshaking this edge takes priority over its (empty) latch.
    wr_addr  = aw_hs ? S_AXI_AWADDR[AW-1:2] : aw_addr_q;
    wr_data  = w_hs ? S_AXI_WDATA : w_data_q;
    wr_strb  = w_hs ? S_AXI_WSTRB : w_strb_q;
    do_write = (aw_lat_q | aw_hs) & (w_lat_q | w_hs);
    wr_oor   = |wr_addr[AW-1:4];
    wr_idx   = wr_addr[3:2];
    wr_resp  = wr_oor ? RESP_DECERR : (wr_idx == 2'd3) ? RESP_SLVERR : RESP_OKAY;
    wr_en    = do_write & ~wr_oor & (wr_idx != 2'd3);
    case (wr_idx)
      2'd0:    wr_cur = ctrl0_q;
      2'd1:    wr_cur = ctrl1_q;
      2'd2:    wr_cur = ctrl2_q;
      default: wr_cur = 32'd0;
    endcase
    for (int b = 0; b < 4; b++)
      wr_merged[8*b +: 8] = wr_strb[b] ? wr_data[8*b +: 8] : wr_cur[8*b +: 8];
    bvalid_n = do_write ? 1'b1 : (bvalid_q & ~S_AXI_BREADY);
    aw_lat_n = ~do_write & (aw_lat_q | aw_hs);
    w_lat_n  = ~do_write & (w_lat_q | w_hs);
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      ctrl0_q   <= 32'd0;
      ctrl1_q   <= 32'd0;
      ctrl2_q   <= 32'd0;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      pulse_q   <= 3'd0;
    end else begin
      aw_lat_q <= aw_lat_n;
      w_lat_q  <= w_lat_n;
      if (aw_hs) aw_addr_q <= S_AXI_AWADDR[AW-1:2];
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      // Readies look at next-state so the B-handshake cycle accepts nothing.
      awready_q <= ~aw_lat_n & ~bvalid_n;
      wready_q  <= ~w_lat_n & ~bvalid_n;
      bvalid_q  <= bvalid_n;
      if (do_write) bresp_q <= wr_resp;
      pulse_q <= wr_en ? (3'b001 << wr_idx) : 3'b000;
      if (wr_en) begin
        case (wr_idx)
          2'd0:    ctrl0_q <= wr_merged;
          2'd1:    ctrl1_q <= wr_merged;
          default: ctrl2_q <= wr_merged;
        endcase
      end
    end
  end

  // Read path: reads ctrl_q before any same-edge write lands, giving the old value.
  logic        ar_hs, rd_oor, rvalid_n;
  logic [1:0]  rd_idx;
  logic [31:0] rd_val;

  always_comb begin
    ar_hs    = S_AXI_ARVALID & arready_q;
    rd_oor   = |S_AXI_ARADDR[AW-1:4];
    rd_idx   = S_AXI_ARADDR[3:2];
    rvalid_n = ar_hs ? 1'b1 : (rvalid_q & ~S_AXI_RREADY);
    case (rd_idx)
      2'd0:    rd_val = ctrl0_q;
      2'd1:    rd_val = ctrl1_q;
      2'd2:    rd_val = ctrl2_q;
      default: rd_val = status_in;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
    end else begin
      arready_q <= ~rvalid_n;
      rvalid_q  <= rvalid_n;
      if (ar_hs) begin
        rdata_q <= rd_oor ? 32'd0 : rd_val;
        rresp_q <= rd_oor ? RESP_DECERR : RESP_OKAY;
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;
  assign ctrl0_out     = ctrl0_q;
  assign ctrl1_out     = ctrl1_q;
  assign ctrl2_out     = ctrl2_q;
  assign ctrl_wr_pulse = pulse_q;

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Bench for axi4_lite_slave_regfile: directed scenarios plus randomized traffic
// checked against a register-map model (array of words + response rules).
module tb_axi4_lite_slave_regfile;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, status = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic        arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0]  bresp, rresp;
  logic [31:0] c0, c1, c2;
  logic [2:0]  pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_ctrl [3];

  always #5 clk = ~clk;

  axi4_lite_slave_regfile dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_b),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .ctrl0_out(c0), .ctrl1_out(c1), .ctrl2_out(c2),
    .status_in(status), .ctrl_wr_pulse(pulse)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Register-map model: apply one write and return the expected response and pulse.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output logic [2:0] pls);
    int idx;
    idx  = int'((addr / 4) % 4);
    pls  = 3'b000;
    if (addr / 16 != 0) resp = 2'b11;
    else if (idx == 3) resp = 2'b10;
    else begin
      resp = 2'b00;
      pls  = 3'(1 << idx);
      for (int b = 0; b < 4; b++)
        if (strb[b]) m_ctrl[idx][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
    int idx;
    idx = int'((addr / 4) % 4);
    if (addr / 16 != 0) begin d = 32'd0; resp = 2'b11; end
    else begin
      d    = (idx == 3) ? status : m_ctrl[idx];
      resp = 2'b00;
    end
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_ctrl0"}, c0, m_ctrl[0]);
    check({tag, "_ctrl1"}, c1, m_ctrl[1]);
    check({tag, "_ctrl2"}, c2, m_ctrl[2]);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly);
    logic aw_done, w_done, aw_go, w_go;
    logic [1:0] er;
    logic [2:0] ep;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      if (aw_done && !w_done) check("awready_while_latched", awready, 0);
      if (w_done && !aw_done) check("wready_while_latched", wready, 0);
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr  = addr;
      wvalid  = !w_done && cyc >= w_dly;
      wdata   = data;
      wstrb   = strb;
      aw_go   = awvalid && awready;
      w_go    = wvalid && wready;
      @(posedge clk);
      aw_done = aw_done | aw_go;
      w_done  = w_done | w_go;
      cyc++;
    end
    check("wr_handshake_done", 32'(aw_done && w_done), 1);
    model_write(addr, data, strb, er, ep);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    check("bvalid_set", bvalid, 1);
    check("bresp", bresp, er);
    check("wr_pulse", pulse, ep);
    check_ctrl("after_wr");
    bready = 0;
    for (int k = 0; k < b_dly; k++) begin
      @(posedge clk); @(negedge clk);
      check("bvalid_hold", bvalid, 1);
      check("bresp_hold", bresp, er);
      check("awready_bwait", awready, 0);
      check("wready_bwait", wready, 0);
      check("pulse_one_cycle", pulse, 0);
    end
    bready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0;
    check("bvalid_clear", bvalid, 0);
    check("pulse_clear", pulse, 0);
    check("awready_after_b", awready, 1);
    check("wready_after_b", wready, 1);
  endtask

  task automatic axi_read(input logic [31:0] addr, input int r_dly);
    logic [31:0] ed;
    logic [1:0]  er;
    int cyc;
    @(negedge clk);
    araddr = addr; arvalid = 1; cyc = 0;
    while (!arready && cyc < 20) begin @(negedge clk); cyc++; end
    check("arready", arready, 1);
    model_read(addr, ed, er);
    @(posedge clk); @(negedge clk);
    arvalid = 0;
    check("rvalid_set", rvalid, 1);
    check("rdata", rdata, ed);
    check("rresp", rresp, er);
    rready = 0;
    for (int k = 0; k < r_dly; k++) begin
      @(posedge clk); @(negedge clk);
      check("rvalid_hold", rvalid, 1);
      check("rdata_hold", rdata, ed);
      check("arready_rwait", arready, 0);
    end
    rready = 1;
    @(posedge clk); @(negedge clk);
    rready = 0;
    check("rvalid_clear", rvalid, 0);
    check("arready_after_r", arready, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, awready, 0);
    check({tag, "_wready"}, wready, 0);
    check({tag, "_arready"}, arready, 0);
    check({tag, "_bvalid"}, bvalid, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_bresp"}, bresp, 0);
    check({tag, "_rresp"}, rresp, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_pulse"}, pulse, 0);
    check({tag, "_c0"}, c0, 0);
    check({tag, "_c1"}, c1, 0);
    check({tag, "_c2"}, c2, 0);
  endtask

  initial begin
    logic [31:0] a, d, old;
    logic [1:0]  er;
    logic [2:0]  ep;
    for (int i = 0; i < 3; i++) m_ctrl[i] = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_b = 1;
    @(posedge clk); @(negedge clk);
    check("rel_awready", awready, 1);
    check("rel_wready", wready, 1);
    check("rel_arready", arready, 1);

    // Same-cycle AW/W to ctrl1
    axi_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    // W first, AW three cycles later, single byte lane
    axi_write(32'h0, 32'h11223344, 4'hF, 0, 0, 0);
    axi_write(32'h0, 32'h000000AA, 4'h1, 3, 0, 1);
    check("byte_merge_ctrl0", c0, 32'h112233AA);
    // AW first, then W
    axi_write(32'h8, 32'h55667788, 4'hA, 0, 2, 0);
    // Error responses
    axi_write(32'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    axi_write(32'h10, 32'hFFFFFFFF, 4'hF, 1, 0, 0);
    axi_read(32'h20, 0);
    // Zero strobe: no data change but still pulses
    axi_write(32'h6, 32'h12345678, 4'h0, 0, 0, 0);
    // Long B stall
    axi_write(32'h8, 32'h0BADF00D, 4'hF, 0, 0, 5);
    // Status read with long R stall
    status = 32'hCAFEF00D;
    axi_read(32'hC, 4);
    axi_read(32'h5, 1);

    // Read and write of ctrl2 completing on the same edge returns the old value
    @(negedge clk);
    old = m_ctrl[2];
    awaddr = 32'h8; awvalid = 1; wdata = 32'hA5A5A5A5; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h8; arvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0; wvalid = 0; arvalid = 0;
    model_write(32'h8, 32'hA5A5A5A5, 4'hF, er, ep);
    check("same_edge_rdata_old", rdata, old);
    check("same_edge_rvalid", rvalid, 1);
    check("same_edge_bvalid", bvalid, 1);
    check("same_edge_ctrl2_new", c2, m_ctrl[2]);
    bready = 1; rready = 1;
    @(posedge clk); @(negedge clk);
    bready = 0; rready = 0;
    check("same_edge_b_clear", bvalid, 0);
    check("same_edge_r_clear", rvalid, 0);

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 4))
        0, 1, 2, 3: a = 32'($urandom_range(0, 15));
        default:    a = $urandom | 32'h10;
      endcase
      d = $urandom;
      if ($urandom_range(0, 2) == 2) begin
        status = $urandom;
        axi_read(a, $urandom_range(0, 3));
      end else begin
        axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    // Reset while AW is latched and W is still pending
    @(negedge clk);
    awaddr = 32'h4; awvalid = 1;
    @(posedge clk); @(negedge clk);
    awvalid = 0;
    check("aw_latched_awready", awready, 0);
    #2 rst_b = 0;
    #1 check_all_zero("mid_reset");
    for (int i = 0; i < 3; i++) m_ctrl[i] = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("mid_reset_hold");
    rst_b = 1;
    @(posedge clk); @(negedge clk);
    check("rerel_awready", awready, 1);
    check("rerel_wready", wready, 1);
    check("rerel_arready", arready, 1);
    check("rerel_bvalid", bvalid, 0);
    axi_write(32'h8, 32'h13579BDF, 4'hF, 0, 0, 0);
    check("post_reset_ctrl1", c1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=%0d exp=0", 1);
    $fatal(1);
  end

endmodule

// File: doc/axi4_lite_slave_regfile.md
AXI4_LITE_SLAVE_REGFILE -- requirements
Module: axi4_lite_slave_regfile

Interface
REQ-001 The block SHALL have parameter C_S_AXI_ADDR_WIDTH, default 32, the AXI address width.
REQ-002 The block SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, the AXI data width; only 32 is supported.
REQ-003 The block SHALL have port m_axi_aclk, input, 1, the clock; all logic is rising-edge.
REQ-004 The block SHALL have port m_axi_aresetn, input, 1, the reset; asynchronous, active-low.
REQ-005 The block SHALL have ports S_AXI_AWADDR (input, ADDR_WIDTH), S_AXI_AWVALID (input, 1) and S_AXI_AWREADY (output, 1) forming the write address channel.
REQ-006 The block SHALL have ports S_AXI_WDATA (input, 32), S_AXI_WSTRB (input, 4), S_AXI_WVALID (input, 1) and S_AXI_WREADY (output, 1) forming the write data channel.
REQ-007 The block SHALL have ports S_AXI_BRESP (output, 2), S_AXI_BVALID (output, 1) and S_AXI_BREADY (input, 1) forming the write response channel.
REQ-008 The block SHALL have ports S_AXI_ARADDR (input, ADDR_WIDTH), S_AXI_ARVALID (input, 1) and S_AXI_ARREADY (output, 1) forming the read address channel.
REQ-009 The block SHALL have ports S_AXI_RDATA (output, 32), S_AXI_RRESP (output, 2), S_AXI_RVALID (output, 1) and S_AXI_RREADY (input, 1) forming the read data channel.
REQ-010 The block SHALL have ports ctrl0_out, ctrl1_out and ctrl2_out, each output, 32, carrying the current contents of the RW registers at offsets 0x0, 0x4 and 0x8.
REQ-011 The block SHALL have port status_in, input, 32, the read-only value returned at offset 0xC.
REQ-012 The block SHALL have port ctrl_wr_pulse, output, 3, a one-cycle pulse per RW register on each successful write to it.

Function
REQ-013 Decode SHALL use addr[3:2] to select the register; addr[ADDR_WIDTH-1:4] != 0 SHALL be out of range. addr[1:0] SHALL be ignored.
REQ-014 S_AXI_AWREADY SHALL be 1 iff no write address is latched and S_AXI_BVALID=0. S_AXI_WREADY SHALL be 1 iff no write data is latched and S_AXI_BVALID=0.
REQ-015 AW and W handshakes SHALL be accepted independently, in either order or in the same cycle. Each accepted address/data+strobe SHALL be held until both are present.
REQ-016 On the edge where both address and data become available (latched, or handshaking that edge), the block SHALL perform the write, set S_AXI_BVALID=1 and clear both latches.
REQ-017 Write effect SHALL be a byte-wise update: byte i of the target register is taken from WDATA when WSTRB[i]=1, else retained. The matching ctrl_wr_pulse bit SHALL be 1 for the following cycle only; WSTRB=0 still pulses.
REQ-018 BRESP SHALL be OKAY (00) for offsets 0x0–0x8, SLVERR (10) for 0xC with no state change and no pulse, and DECERR (11) for out-of-range addresses with no state change.
REQ-019 S_AXI_BVALID and BRESP SHALL be held stable until the edge where S_AXI_BREADY=1; that edge SHALL clear BVALID. Handshakes SHALL NOT be accepted in that same cycle, so the minimum write period is 2 cycles.
REQ-020 S_AXI_ARREADY SHALL be 1 iff S_AXI_RVALID=0. On the AR handshake edge, RDATA/RRESP SHALL be captured and S_AXI_RVALID set to 1 (1-cycle latency).
REQ-021 Read data SHALL be ctrl0/1/2 or status_in sampled at the AR edge, with RRESP=OKAY; an out-of-range read SHALL return RDATA=0 and RRESP=DECERR.
REQ-022 RVALID, RDATA and RRESP SHALL be held stable until the edge where S_AXI_RREADY=1, which clears RVALID.
REQ-023 Read and write paths SHALL be fully independent. A read and write of the same register completing on the same edge SHALL return the pre-write value.
REQ-024 Ready and valid outputs SHALL be registered. No output SHALL depend combinationally on any *VALID or *READY input.

Reset
REQ-025 While m_axi_aresetn=0, all READY/VALID outputs, BRESP, RRESP, RDATA, ctrl0/1/2_out and ctrl_wr_pulse SHALL be 0, and both latches SHALL be cleared.
REQ-026 A reset asserted mid-transaction SHALL abort it, discarding latched AW/W and pending B/R. The first cycle after deassertion SHALL show AWREADY=WREADY=ARREADY=1.

Verification
REQ-027 Same-cycle AW=0x4 and W=0xDEADBEEF with WSTRB=0xF, BREADY=1 -> BVALID=1 with BRESP=00 next cycle, ctrl1_out=0xDEADBEEF, ctrl_wr_pulse=3'b010 for one cycle.
REQ-028 W=0x000000AA with WSTRB=0x1, then AW=0x0 three cycles later, with ctrl0=0x11223344 -> WREADY=0 while waiting, ctrl0_out=0x112233AA, BRESP=00.
REQ-029 Write to 0xC -> BRESP=10 and no ctrl change; write to 0x10 -> BRESP=11; read of 0x20 -> RDATA=0, RRESP=11.
REQ-030 Read of 0xC with status_in=0xCAFEF00D and RREADY held 0 for 4 cycles -> RVALID/RDATA stable throughout, ARREADY=0 until the RREADY edge.
REQ-031 BREADY=0 for 5 cycles after a write -> AWREADY=WREADY=0 and a second AW is not accepted until the B handshake.
REQ-032 Reset pulsed while AW is latched and W is pending -> all outputs 0 during reset, and after release a fresh write to 0x8 completes with BRESP=00.
